// File: rtl/bcd_to_bin_if.sv
// Request/result bundle for the BCD-to-binary converter.
// The master issues start with a packed 4-digit BCD word and watches the
// ready/done_tick handshake; the slave converts and reports the result.
interface bcd_to_bin_if;
  logic        start;
  logic [15:0] bcd_in;
  logic        ready;
  logic        done_tick;
  logic [13:0] bin_out;
  logic        err;

  modport master (
    output start, bcd_in,
    input  ready, done_tick, bin_out, err
  );

  modport slave (
    input  start, bcd_in,
    output ready, done_tick, bin_out, err
  );
endinterface

// File: rtl/bcd_to_bin.sv
// Iterative 4-digit BCD to 14-bit binary converter (reverse double-dabble).
// One bit of the result is produced per OP cycle, so a valid conversion
// takes 14 OP cycles followed by a single DONE cycle. Invalid digits skip
// OP entirely and report err with a zero result.
module bcd_to_bin (
  input  logic           clk,
  input  logic           reset,
  bcd_to_bin_if.slave    bus
);

  localparam int BCD_W = 16;
  localparam int BIN_W = 14;
  localparam logic [3:0] LAST_STEP = 4'd13;

  typedef enum logic [1:0] {IDLE, OP, DONE} state_t;

  state_t             state, state_nxt;
  logic [BCD_W-1:0]   bcd_reg;
  logic [BIN_W-1:0]   bin_reg;
  logic [3:0]         cnt;
  logic [BIN_W-1:0]   bin_out_r;
  logic               err_r;
  logic               ready_c;
  logic               done_c;
  logic               in_valid;

  logic [BCD_W+BIN_W-1:0] shifted;
  logic [BCD_W-1:0]       bcd_step;
  logic [BIN_W-1:0]       bin_step;

  // True when every packed digit is a legal decimal digit (0..9).
  function automatic logic digits_valid(input logic [BCD_W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (v[4*d +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // After a right shift, a digit >= 8 received a carried-in 10 worth of
  // weight as 8; subtracting 3 restores a correct decimal digit.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int d = 0; d < 4; d++) begin
      if (r[4*d +: 4] >= 4'd8) r[4*d +: 4] = r[4*d +: 4] - 4'd3;
    end
    return r;
  endfunction

  assign in_valid = digits_valid(bus.bcd_in);
  assign shifted  = {bcd_reg, bin_reg} >> 1;
  assign bin_step = shifted[BIN_W-1:0];
  assign bcd_step = dabble_adjust(shifted[BCD_W+BIN_W-1:BIN_W]);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    ready_c   = 1'b0;
    done_c    = 1'b0;
    case (state)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.start) state_nxt = in_valid ? OP : DONE;
      end
      OP: begin
        if (cnt == 4'd0) state_nxt = DONE;
      end
      DONE: begin
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift registers, step counter and the held result.
  always_ff @(posedge clk) begin
    if (reset) begin
      bcd_reg   <= '0;
      bin_reg   <= '0;
      cnt       <= '0;
      bin_out_r <= '0;
      err_r     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            bcd_reg <= bus.bcd_in;
            bin_reg <= '0;
            if (in_valid) begin
              cnt <= LAST_STEP;
            end else begin
              bin_out_r <= '0;
              err_r     <= 1'b1;
            end
          end
        end
        OP: begin
          bcd_reg <= bcd_step;
          bin_reg <= bin_step;
          cnt     <= cnt - 4'd1;
          if (cnt == 4'd0) begin
            bin_out_r <= bin_step;
            err_r     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready     = ready_c;
  assign bus.done_tick = done_c;
  assign bus.bin_out   = bin_out_r;
  assign bus.err       = err_r;

endmodule
